// File: rtl/blackjack_autoplayer.sv
// blackjack_autoplayer
// Automated player for the blackjack game engine. It resets the game, kicks
// it out of idle, deals two player cards from a 6-bit LFSR shoe, hits below
// STAND_AT, stands, pulses the dealer phase along and tallies the outcome of
// every round over a programmed number of rounds.
//
// Build option: define BJ_AUTOPLAYER_STATS_EN to implement the wins, losses,
// draws and blackjacks counters. Without it those outputs are tied to zero.
// games_played, timeout_err and all sequencing are identical in both builds.
module blackjack_autoplayer #(
  parameter int STAND_AT = 17,
  parameter int GAP      = 2,
  parameter int TIMEOUT  = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_games,
  input  logic [5:0]       seed,
  input  logic [5:0]       player_sum,
  input  logic [5:0]       dealer_sum,
  input  logic             win,
  input  logic             lose,
  input  logic             draw,
  input  logic             blackjack,
  output logic             game_reset,
  output logic [4:0]       card_in,
  output logic             submit,
  output logic             hit,
  output logic             stand,
  output logic [CNT_W-1:0] games_played,
  output logic [CNT_W-1:0] wins,
  output logic [CNT_W-1:0] losses,
  output logic [CNT_W-1:0] draws,
  output logic [CNT_W-1:0] blackjacks,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  // Sequencer states
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_GRST   = 4'd1;
  localparam logic [3:0] S_KICK   = 4'd2;
  localparam logic [3:0] S_DEAL   = 4'd3;
  localparam logic [3:0] S_DECIDE = 4'd4;
  localparam logic [3:0] S_HIT    = 4'd5;
  localparam logic [3:0] S_STAND  = 4'd6;
  localparam logic [3:0] S_DEALER = 4'd7;
  localparam logic [3:0] S_RECORD = 4'd8;
  localparam logic [3:0] S_FIN    = 4'd9;

  localparam int GAP_W = (GAP < 1) ? 1 : $clog2(GAP + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  // A GAP below one would let two submits run back to back; clamp it.
  localparam logic [GAP_W-1:0] GAP_LOAD  = (GAP < 1) ? GAP_W'(1) : GAP_W'(GAP);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [5:0]       STAND_LIM = 6'(STAND_AT);
  localparam logic [5:0]       LFSR_INIT = 6'b000001;

  // Map an LFSR state to a card value 1..10 (faces collapse to 10).
  function automatic logic [4:0] card_of(input logic [5:0] l);
    logic [3:0] v;
    logic [4:0] c;
    v = l[3:0];
    if (v >= 4'd13) begin
      v = v - 4'd13;
    end else begin
      v = v;
    end
    c = {1'b0, v} + 5'd1;
    if (c > 5'd10) begin
      c = 5'd10;
    end else begin
      c = c;
    end
    return c;
  endfunction

  // Fibonacci LFSR step, taps on bits 5 and 4.
  function automatic logic [5:0] lfsr_step(input logic [5:0] l);
    return {l[4:0], l[5] ^ l[4]};
  endfunction

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : (x + CNT_W'(1));
  endfunction

  logic [3:0]       state_r;
  logic [GAP_W-1:0] gap_r;
  logic [TMO_W-1:0] tmo_r;
  logic             deal_cnt_r;
  logic             aborted_r;
  logic [5:0]       lfsr_r;
  logic [CNT_W-1:0] num_games_r;
  logic [CNT_W-1:0] games_played_r;
  logic             game_reset_r;
  logic [4:0]       card_in_r;
  logic             submit_r;
  logic             hit_r;
  logic             stand_r;
  logic             busy_r;
  logic             done_r;
  logic             timeout_err_r;

  logic [4:0]       card_s;
  logic [5:0]       lfsr_nxt_s;
  logic             result_s;
  logic             start_ok_s;
  logic [CNT_W-1:0] gp_inc_s;

  // Shared combinational helpers: current card, next shoe state, accept logic.
  always_comb begin
    card_s     = card_of(lfsr_r);
    lfsr_nxt_s = lfsr_step(lfsr_r);
    result_s   = win | lose | draw;
    gp_inc_s   = sat_inc(games_played_r);
    if ((state_r == S_IDLE) || (state_r == S_FIN)) begin
      start_ok_s = start && (num_games != {CNT_W{1'b0}});
    end else begin
      start_ok_s = 1'b0;
    end
  end

  // Main sequencer: round flow, pulse generation, GAP spacing, dealer watchdog.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r        <= S_IDLE;
      gap_r          <= {GAP_W{1'b0}};
      tmo_r          <= {TMO_W{1'b0}};
      deal_cnt_r     <= 1'b0;
      aborted_r      <= 1'b0;
      lfsr_r         <= LFSR_INIT;
      num_games_r    <= {CNT_W{1'b0}};
      games_played_r <= {CNT_W{1'b0}};
      game_reset_r   <= 1'b1;
      card_in_r      <= 5'd0;
      submit_r       <= 1'b0;
      hit_r          <= 1'b0;
      stand_r        <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      timeout_err_r  <= 1'b0;
    end else begin
      // Pulses last a single cycle unless a state re-arms them.
      submit_r  <= 1'b0;
      hit_r     <= 1'b0;
      card_in_r <= 5'd0;
      case (state_r)
        S_IDLE, S_FIN: begin
          if (start_ok_s) begin
            num_games_r    <= num_games;
            lfsr_r         <= (seed == 6'd0) ? LFSR_INIT : seed;
            games_played_r <= {CNT_W{1'b0}};
            timeout_err_r  <= 1'b0;
            busy_r         <= 1'b1;
            done_r         <= 1'b0;
            game_reset_r   <= 1'b1;
            state_r        <= S_GRST;
          end else begin
            state_r <= state_r;
          end
        end
        S_GRST: begin
          game_reset_r <= 1'b0;
          state_r      <= S_KICK;
        end
        S_KICK: begin
          // Card value 0 only moves the engine out of its idle state.
          submit_r   <= 1'b1;
          gap_r      <= GAP_LOAD;
          deal_cnt_r <= 1'b0;
          state_r    <= S_DEAL;
        end
        S_DEAL: begin
          if (gap_r != {GAP_W{1'b0}}) begin
            gap_r <= gap_r - GAP_W'(1);
          end else begin
            submit_r  <= 1'b1;
            card_in_r <= card_s;
            lfsr_r    <= lfsr_nxt_s;
            gap_r     <= GAP_LOAD;
            if (deal_cnt_r) begin
              state_r <= S_DECIDE;
            end else begin
              deal_cnt_r <= 1'b1;
            end
          end
        end
        S_DECIDE: begin
          // The GAP wait lets the engine settle player_sum after the last pulse.
          if (gap_r != {GAP_W{1'b0}}) begin
            gap_r <= gap_r - GAP_W'(1);
          end else if (result_s) begin
            aborted_r <= 1'b0;
            state_r   <= S_RECORD;
          end else if (player_sum >= STAND_LIM) begin
            stand_r <= 1'b1;
            state_r <= S_STAND;
          end else begin
            state_r <= S_HIT;
          end
        end
        S_HIT: begin
          hit_r     <= 1'b1;
          submit_r  <= 1'b1;
          card_in_r <= card_s;
          lfsr_r    <= lfsr_nxt_s;
          gap_r     <= GAP_LOAD;
          state_r   <= S_DECIDE;
        end
        S_STAND: begin
          tmo_r   <= {TMO_W{1'b0}};
          gap_r   <= {GAP_W{1'b0}};
          state_r <= S_DEALER;
        end
        S_DEALER: begin
          if (result_s) begin
            aborted_r <= 1'b0;
            state_r   <= S_RECORD;
          end else if (tmo_r == TMO_LAST) begin
            // Engine never answered: flag it and close the round uncounted.
            timeout_err_r <= 1'b1;
            aborted_r     <= 1'b1;
            state_r       <= S_RECORD;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
            if (gap_r == {GAP_W{1'b0}}) begin
              submit_r <= 1'b1;
              gap_r    <= GAP_LOAD;
            end else begin
              gap_r <= gap_r - GAP_W'(1);
            end
          end
        end
        S_RECORD: begin
          games_played_r <= gp_inc_s;
          stand_r        <= 1'b0;
          game_reset_r   <= 1'b1;
          if (gp_inc_s == num_games_r) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= S_FIN;
          end else begin
            state_r <= S_GRST;
          end
        end
        default: begin
          state_r      <= S_IDLE;
          game_reset_r <= 1'b1;
          stand_r      <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign game_reset   = game_reset_r;
  assign card_in      = card_in_r;
  assign submit       = submit_r;
  assign hit          = hit_r;
  assign stand        = stand_r;
  assign games_played = games_played_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign timeout_err  = timeout_err_r;

`ifdef BJ_AUTOPLAYER_STATS_EN
  logic [CNT_W-1:0] wins_r;
  logic [CNT_W-1:0] losses_r;
  logic [CNT_W-1:0] draws_r;
  logic [CNT_W-1:0] blackjacks_r;
  logic             unused_inputs_s;

  assign unused_inputs_s = ^dealer_sum;

  // Outcome tally: win beats draw beats lose; aborted rounds add nothing.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wins_r       <= {CNT_W{1'b0}};
      losses_r     <= {CNT_W{1'b0}};
      draws_r      <= {CNT_W{1'b0}};
      blackjacks_r <= {CNT_W{1'b0}};
    end else if (start_ok_s) begin
      wins_r       <= {CNT_W{1'b0}};
      losses_r     <= {CNT_W{1'b0}};
      draws_r      <= {CNT_W{1'b0}};
      blackjacks_r <= {CNT_W{1'b0}};
    end else if ((state_r == S_RECORD) && !aborted_r) begin
      if (win) begin
        wins_r <= sat_inc(wins_r);
      end else if (draw) begin
        draws_r <= sat_inc(draws_r);
      end else if (lose) begin
        losses_r <= sat_inc(losses_r);
      end else begin
        wins_r <= wins_r;
      end
      if (blackjack) begin
        blackjacks_r <= sat_inc(blackjacks_r);
      end else begin
        blackjacks_r <= blackjacks_r;
      end
    end else begin
      wins_r <= wins_r;
    end
  end

  assign wins       = wins_r;
  assign losses     = losses_r;
  assign draws      = draws_r;
  assign blackjacks = blackjacks_r;
`else
  logic unused_inputs_s;

  assign unused_inputs_s = ^{dealer_sum, blackjack};
  assign wins            = {CNT_W{1'b0}};
  assign losses          = {CNT_W{1'b0}};
  assign draws           = {CNT_W{1'b0}};
  assign blackjacks      = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_blackjack_autoplayer.sv
// Self-checking bench for blackjack_autoplayer. A behavioural game stub
// answers the player's pulses; a round-level reference model predicts the
// card stream, hit count and session statistics from the shoe rules.
module tb_blackjack_autoplayer;
  localparam int CNT_W    = 16;
  localparam int STAND_AT = 17;
  localparam int TIMEOUT  = 64;
`ifdef BJ_AUTOPLAYER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_games = '0;
  logic [5:0]       seed = 6'd0;
  logic [5:0]       player_sum, dealer_sum;
  logic             win, lose, draw, blackjack;
  logic             game_reset, submit, hit, stand, busy, done, timeout_err;
  logic [4:0]       card_in;
  logic [CNT_W-1:0] games_played, wins, losses, draws, blackjacks;

  blackjack_autoplayer #(.STAND_AT(STAND_AT), .GAP(2), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_games(num_games), .seed(seed),
    .player_sum(player_sum), .dealer_sum(dealer_sum), .win(win), .lose(lose), .draw(draw),
    .blackjack(blackjack), .game_reset(game_reset), .card_in(card_in), .submit(submit),
    .hit(hit), .stand(stand), .games_played(games_played), .wins(wins), .losses(losses),
    .draws(draws), .blackjacks(blackjacks), .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Per-round stub behaviour: mode 0 dealer answers, 1 natural, 2 silent dealer.
  int rmode[8];
  int rk[8];
  int rout[8];
  int gr_cnt = 0;
  int gr_base = 0;
  logic gr_prev = 1'b1;
  int n_sub = 0;
  int dsub = 0;

  function automatic int ridx();
    int r;
    r = gr_cnt - gr_base - 1;
    if (r < 0) r = 0;
    if (r > 7) r = 7;
    return r;
  endfunction

  initial dealer_sum = 6'd0;

  // Game engine stub: sums update one cycle after submit, flags hold until game_reset.
  always @(posedge clk) begin
    gr_prev <= game_reset;
    if (gr_prev && !game_reset) gr_cnt <= gr_cnt + 1;
    if (!reset_n || game_reset) begin
      player_sum <= 6'd0;
      win <= 1'b0; lose <= 1'b0; draw <= 1'b0; blackjack <= 1'b0;
      n_sub <= 0; dsub <= 0;
    end else if (submit) begin
      if (stand) begin
        dsub <= dsub + 1;
        if (rmode[ridx()] == 0 && dsub + 1 == rk[ridx()]) begin
          if (rout[ridx()] == 0) win <= 1'b1;
          else if (rout[ridx()] == 1) lose <= 1'b1;
          else draw <= 1'b1;
        end
      end else begin
        n_sub <= n_sub + 1;
        if (n_sub != 0) begin
          if (rmode[ridx()] == 1 && n_sub == 2) begin
            player_sum <= 6'd21; win <= 1'b1; blackjack <= 1'b1;
          end else begin
            player_sum <= player_sum + {1'b0, card_in};
            if (int'(player_sum) + int'(card_in) > 21) lose <= 1'b1;
          end
        end
      end
    end
  end

  // Output monitor, sampled on the falling edge.
  int cards_q[$];
  int hit_cnt = 0;
  int kick_cnt = 0;
  int bad_hit = 0;
  int stand_run = 0;
  int to_run = -1;
  logic to_prev = 1'b0;
  always @(negedge clk) begin
    if (submit === 1'b1 && stand === 1'b0) begin
      if (card_in != 5'd0) cards_q.push_back(int'(card_in));
      else kick_cnt <= kick_cnt + 1;
    end
    if (hit === 1'b1) hit_cnt <= hit_cnt + 1;
    if (hit === 1'b1 && submit !== 1'b1) bad_hit <= bad_hit + 1;
    stand_run <= (stand === 1'b1) ? stand_run + 1 : 0;
    to_prev <= timeout_err;
    if (timeout_err === 1'b1 && to_prev === 1'b0) to_run <= stand_run;
  end

  function automatic int mcard(input int l);
    int v;
    v = l % 16;
    if (v >= 13) v = v - 13;
    v = v + 1;
    if (v > 10) v = 10;
    return v;
  endfunction

  function automatic int mnext(input int l);
    return ((l * 2) % 64) + ((((l / 32) % 2) + ((l / 16) % 2)) % 2);
  endfunction

  task automatic check_reset_values(input string pfx);
    check_eq({pfx, "_game_reset"}, game_reset, 1);
    check_eq({pfx, "_card_in"}, card_in, 0);
    check_eq({pfx, "_pulses"}, {submit, hit, stand}, 0);
    check_eq({pfx, "_games_played"}, games_played, 0);
    check_eq({pfx, "_stats"}, wins | losses | draws | blackjacks, 0);
    check_eq({pfx, "_status"}, {busy, done, timeout_err}, 0);
  endtask

  task automatic run_session(input int sd, input int n, input bit midstart);
    int l, c, s, ew, el, ed, eb, eh, eto, cb, hb, kb, bh;
    int ecards[$];
    ew = 0; el = 0; ed = 0; eb = 0; eh = 0; eto = 0;
    l = (sd == 0) ? 1 : sd;
    for (int r = 0; r < n; r++) begin
      c = mcard(l); l = mnext(l); ecards.push_back(c); s = c;
      c = mcard(l); l = mnext(l); ecards.push_back(c); s = s + c;
      if (rmode[r] == 1) begin
        ew++; eb++;
      end else begin
        while (s < STAND_AT) begin
          c = mcard(l); l = mnext(l); ecards.push_back(c); s = s + c; eh++;
        end
        if (s > 21) el++;
        else if (rmode[r] == 0) begin
          if (rout[r] == 0) ew++;
          else if (rout[r] == 1) el++;
          else ed++;
        end else eto = 1;
      end
    end
    cb = cards_q.size(); hb = hit_cnt; kb = kick_cnt; bh = bad_hit;
    @(negedge clk);
    gr_base = gr_cnt;
    seed = 6'(sd); num_games = CNT_W'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_t1", busy, 1);
    @(negedge clk);
    check_eq("game_reset_t2", game_reset, 0);
    @(negedge clk);
    check_eq("kick_t3", {submit, card_in}, 6'b100000);
    for (int i = 0; i < 6000 && done !== 1'b1; i++) begin
      if (midstart && i == 30) begin
        check_eq("busy_midstart", busy, 1);
        seed = 6'd9; num_games = CNT_W'(7); start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("done_seen", done, 1);
    check_eq("busy_end", busy, 0);
    check_eq("game_reset_fin", game_reset, 1);
    check_eq("games_played", games_played, n);
    check_eq("wins", wins, STATS ? ew : 0);
    check_eq("losses", losses, STATS ? el : 0);
    check_eq("draws", draws, STATS ? ed : 0);
    check_eq("blackjacks", blackjacks, STATS ? eb : 0);
    check_eq("timeout_err", timeout_err, eto);
    check_eq("hits", hit_cnt - hb, eh);
    check_eq("hit_without_submit", bad_hit - bh, 0);
    check_eq("kicks", kick_cnt - kb, n);
    check_eq("game_reset_pulses", gr_cnt - gr_base, n);
    check_eq("card_count", cards_q.size() - cb, ecards.size());
    for (int i = 0; i < ecards.size() && cb + i < cards_q.size(); i++)
      check_eq("card", cards_q[cb + i], ecards[i]);
  endtask

  initial begin
    int cb0;
    for (int i = 0; i < 8; i++) begin rmode[i] = 0; rk[i] = 1; rout[i] = 0; end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_values("reset");

    // num_games of zero must not start a session.
    num_games = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_eq("zero_games_busy", busy, 0);
    check_eq("zero_games_game_reset", game_reset, 1);

    // Seed 0: deal 2 then 3, first hit 5; dealer answers win on first submit.
    rmode[0] = 0; rk[0] = 1; rout[0] = 0;
    cb0 = cards_q.size();
    run_session(0, 1, 1'b0);
    check_eq("first_deal_card", (cards_q.size() > cb0) ? cards_q[cb0] : 0, 2);
    check_eq("second_deal_card", (cards_q.size() > cb0 + 1) ? cards_q[cb0 + 1] : 0, 3);
    check_eq("first_hit_card", (cards_q.size() > cb0 + 2) ? cards_q[cb0 + 2] : 0, 5);

    // Natural 21 straight after the deal.
    rmode[0] = 1;
    run_session($urandom_range(0, 63), 1, 1'b0);

    // Silent dealer: watchdog aborts after TIMEOUT dealer cycles.
    rmode[0] = 2;
    run_session(0, 1, 1'b0);
    check_eq("timeout_window", (to_run >= TIMEOUT && to_run <= TIMEOUT + 2) ? 1 : 0, 1);

    // Three rounds lose/draw/lose with a start pulsed mid-session.
    for (int i = 0; i < 3; i++) begin rmode[i] = 0; rk[i] = i + 1; end
    rout[0] = 1; rout[1] = 2; rout[2] = 1;
    run_session(0, 3, 1'b1);

    // Randomized sessions.
    for (int s = 0; s < 5; s++) begin
      int n, m;
      n = $urandom_range(1, 4);
      for (int i = 0; i < 8; i++) begin
        m = $urandom_range(0, 9);
        rmode[i] = (m < 6) ? 0 : ((m < 8) ? 1 : 2);
        rk[i] = $urandom_range(1, 4);
        rout[i] = $urandom_range(0, 2);
      end
      run_session($urandom_range(0, 63), n, 1'b0);
    end

    // Reset asserted during the dealer phase.
    rmode[0] = 2;
    @(negedge clk);
    seed = 6'd0; num_games = CNT_W'(1); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 300 && stand !== 1'b1; i++) @(negedge clk);
    check_eq("stand_reached", stand, 1);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_values("midround_reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Recovery session after the reset.
    rmode[0] = 0; rk[0] = 2; rout[0] = 2;
    rmode[1] = 1;
    run_session($urandom_range(0, 63), 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/blackjack_autoplayer.md
# blackjack_autoplayer

Automated player agent that drives the player side of the blackjack game engine: card entry, `submit`, `hit` and `stand`. It resets the game, deals the two opening player cards from its own LFSR shoe, and plays a fixed threshold strategy. It pulses `submit` through the dealer phase and tallies outcomes over a programmed number of rounds. It sits beside the game engine in soak and regression harnesses and on the FPGA demo board.

## Interface
- `STAND_AT`, 17: stand when `player_sum >= STAND_AT`; otherwise hit.
- `GAP`, 2: idle cycles inserted after every `submit` pulse (minimum 1).
- `TIMEOUT`, 64: maximum cycles in the dealer phase with no result flag before the round is aborted.
- `CNT_W`, 16: width of `num_games` and of all statistics counters.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request to begin a session; honoured only in IDLE or FIN.
- `num_games` in CNT_W: rounds per session; sampled on an accepted `start`. A value of 0 makes `start` ignored.
- `seed` in 6: LFSR seed; sampled on an accepted `start`. A value of 0 loads 6'b000001.
- `player_sum`, `dealer_sum` in 6: from the game engine.
- `win`, `lose`, `draw`, `blackjack` in 1: from the game engine.
- `game_reset` out 1: active-high reset to the game engine.
- `card_in` out 5: player card, value 1..10; valid when `submit` is high during the deal.
- `submit`, `hit` out 1: single-cycle pulses.
- `stand` out 1: level signal.
- `games_played`, `wins`, `losses`, `draws`, `blackjacks` out CNT_W: statistics counters.
- `busy`, `done`, `timeout_err` out 1: status.

## Operation
- States: IDLE, GRST, KICK, DEAL, DECIDE, HIT, STAND, DEALER, RECORD, FIN. Every `submit` pulse is followed by a GAP sub-count before the next action.
- IDLE: `game_reset`=1. On `start`, load `num_games`/`seed`, clear all counters and `timeout_err`, then go to GRST.
- GRST: hold `game_reset`=1 for one cycle, then drive 0 and go to KICK.
- KICK: one `submit` pulse with `card_in`=0. This moves the game out of its idle state. Then GAP, then DEAL.
- DEAL: two `submit` pulses, each with `card_in`=current card. The LFSR advances on the cycle after each pulse. Then GAP, then DECIDE.
- DECIDE, evaluated every cycle:
  - any of `win`/`lose`/`draw` → RECORD;
  - else `player_sum >= STAND_AT` (this includes bust) → STAND;
  - else → HIT.
- HIT: `hit`=`submit`=1 for one cycle, `card_in`=card, LFSR advances. Then GAP, then DECIDE.
- STAND: assert `stand`=1 and hold it until RECORD exits. Go to DEALER.
- DEALER:
  - one `submit` pulse every GAP+1 cycles;
  - a cycle counter is cleared on entry;
  - any result flag → RECORD;
  - counter reaching TIMEOUT → set sticky `timeout_err`, go to RECORD with the outcome suppressed.
- RECORD, one cycle:
  - `games_played`+1;
  - outcome priority `win` > `draw` > `lose`: exactly one of `wins`/`draws`/`losses` +1, none if aborted;
  - `blackjacks`+1 if `blackjack`;
  - then `games_played`==`num_games` → FIN, else GRST.
- FIN: `done`=1, `game_reset`=1. Counters hold; `start` restarts the session.
- Card generation:
  - LFSR 6-bit Fibonacci, next = {lfsr[4:0], lfsr[5]^lfsr[4]};
  - v=lfsr[3:0], minus 13 if v≥13;
  - card=v+1, clamped to 10 if >10.
- Counters saturate at all-ones.
- `busy`=1 in every state except IDLE and FIN.

## Timing
- Reset values:
  - `game_reset`=1;
  - `card_in`=0;
  - `submit`=`hit`=`stand`=0;
  - all counters 0;
  - `busy`=`done`=`timeout_err`=0;
  - LFSR=6'b000001;
  - state IDLE.
- All outputs are registered.
- Accepted `start` at cycle t: `busy`=1 at t+1. First falling edge of `game_reset` at t+2; KICK `submit` pulse at t+3.
- `player_sum` is sampled in DECIDE no earlier than GAP cycles after the last pulse. The game updates sums one cycle after `submit`.
- `start` while `busy` is ignored, with no effect on counters or state.
- `reset_n` low mid-round: next edge returns to reset values, `game_reset` reasserts, and the round is not counted.
- A result flag that arrives during a GAP is latched by the next DECIDE/DEALER evaluation; flags hold in the game until `game_reset`.

## Configuration
- `BJ_AUTOPLAYER_STATS_EN` defined: `wins`/`losses`/`draws`/`blackjacks` are implemented as specified.
- Undefined: those four outputs are tied to 0 and their registers are removed. `games_played`, `timeout_err` and all sequencing are unchanged.

## Test plan
- Reset, then seed=0, `start` with `num_games`=1: DEAL pulses carry `card_in`=2 then 3; the first HIT card is 5.
- Stub game with `player_sum`=12, then 19 after the first hit: exactly one `hit` pulse, then `stand`=1 held. Stub asserts `win` → `wins`=1, `games_played`=1, `done`=1.
- Stub presents `player_sum`=21 and `blackjack`=`win`=1 after the deal: no `hit` pulse, `wins`=1, `blackjacks`=1.
- Stub never asserts a result in the dealer phase: `timeout_err`=1 after 64 cycles; `games_played`=1; `wins`=`losses`=`draws`=0.
- `num_games`=3, stub alternates `lose`/`draw`/`lose`: three `game_reset` pulses; `losses`=2, `draws`=1, `games_played`=3. A `start` pulsed mid-session is ignored.
- `reset_n` low during DEALER: all outputs return to reset values the next cycle. Build with the macro undefined: `wins`/`losses`/`draws`/`blackjacks` stay 0 while `games_played` still counts.
